// File: rtl/writeback_pkg.sv
// Shared types for the write-back sequencer: queue entry, controller states
// and the push-time sanitising rule.
package writeback_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic                  wen1;
        logic                  wen2;
        logic [REG_ADDR_W-1:0] reg1;
        logic [REG_ADDR_W-1:0] reg2;
        logic [DATA_W-1:0]     data1;
        logic [DATA_W-1:0]     data2;
    } wb_entry_t;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        ACTIVE = 2'd1,
        FULL   = 2'd2
    } wb_state_t;

    // $0 is never written; on a same-register pair port 2 wins.
    function automatic wb_entry_t wb_sanitize(input wb_entry_t e);
        wb_entry_t r;
        r = e;
        if (r.reg1 == '0) r.wen1 = 1'b0;
        if (r.reg2 == '0) r.wen2 = 1'b0;
        if (r.wen1 && r.wen2 && (r.reg1 == r.reg2)) r.wen1 = 1'b0;
        return r;
    endfunction

endpackage

// File: rtl/wb_queue.sv
// Circular buffer of write-back entries with push, pop, flush and count.
// With WB_FORWARD_EN the raw slots and read pointer are exported for lookup.
module wb_queue
    import writeback_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1,
    localparam int ENT_W = $bits(wb_entry_t)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  wb_entry_t        push_entry,
    output wb_entry_t        head_entry,
    output logic [CNT_W-1:0] count
`ifdef WB_FORWARD_EN
    ,
    output logic [PTR_W-1:0]       rd_ptr_o,
    output logic [DEPTH*ENT_W-1:0] entries_flat
`endif
);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Storage is not reset: slots outside [rd_ptr, rd_ptr+count) are never observed.
    always_ff @(posedge clk) begin
        if (push && !reset && !flush) mem[wr_ptr] <= push_entry;
    end

    assign head_entry = mem[rd_ptr];

`ifdef WB_FORWARD_EN
    assign rd_ptr_o = rd_ptr;

    always_comb begin
        entries_flat = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entries_flat[i*ENT_W +: ENT_W] = mem[i];
        end
    end
`endif

endmodule

// File: rtl/writeback_unit.sv
// Write-back sequencer feeding the two register_block write ports.
// Optional macro WB_FORWARD_EN adds the fwd_reg/fwd_hit/fwd_data lookup.
module writeback_unit
    import writeback_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_wen1,
    input  logic                  in_wen2,
    input  logic [REG_ADDR_W-1:0] in_reg1,
    input  logic [REG_ADDR_W-1:0] in_reg2,
    input  logic [DATA_W-1:0]     in_data1,
    input  logic [DATA_W-1:0]     in_data2,
    input  logic                  drain_hold,
    input  logic                  flush,
    output logic [REG_ADDR_W-1:0] write_reg1,
    output logic [REG_ADDR_W-1:0] write_reg2,
    output logic [DATA_W-1:0]     write_data1,
    output logic [DATA_W-1:0]     write_data2,
    output logic                  reg_write,
    output logic                  enable
`ifdef WB_FORWARD_EN
    ,
    input  logic [REG_ADDR_W-1:0] fwd_reg,
    output logic                  fwd_hit,
    output logic [DATA_W-1:0]     fwd_data
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = $bits(wb_entry_t);

    wb_state_t        state_q, state_d;
    wb_entry_t        in_entry, head_entry;
    logic [CNT_W-1:0] count;
    logic             push, pop;

`ifdef WB_FORWARD_EN
    logic [PTR_W-1:0]       rd_ptr;
    logic [DEPTH*ENT_W-1:0] entries_flat;
`endif

    assign in_entry = wb_sanitize('{wen1: in_wen1, wen2: in_wen2,
                                    reg1: in_reg1, reg2: in_reg2,
                                    data1: in_data1, data2: in_data2});

    // in_ready looks only at occupancy, never at a same-cycle pop.
    assign in_ready = (state_q != FULL);
    assign push     = in_valid && in_ready && !flush;
    assign pop      = (state_q != EMPTY) && !drain_hold && !flush;

    wb_queue #(.DEPTH(DEPTH)) u_queue (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .pop        (pop),
        .flush      (flush),
        .push_entry (in_entry),
        .head_entry (head_entry),
        .count      (count)
`ifdef WB_FORWARD_EN
        ,
        .rd_ptr_o     (rd_ptr),
        .entries_flat (entries_flat)
`endif
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:  if (push) state_d = ACTIVE;
            ACTIVE: begin
                if (push && !pop && (count == CNT_W'(DEPTH - 1)))
                    state_d = FULL;
                else if (pop && !push && (count == CNT_W'(1)))
                    state_d = EMPTY;
            end
            FULL:   if (pop && !push) state_d = ACTIVE;
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write_reg1  <= '0;
            write_reg2  <= '0;
            write_data1 <= '0;
            write_data2 <= '0;
            reg_write   <= 1'b0;
            enable      <= 1'b0;
        end else if (flush) begin
            reg_write <= 1'b0;
            enable    <= 1'b0;
        end else if (!drain_hold) begin
            if (pop) begin
                write_reg1  <= head_entry.reg1;
                write_reg2  <= head_entry.reg2;
                write_data1 <= head_entry.data1;
                write_data2 <= head_entry.data2;
                reg_write   <= head_entry.wen1;
                enable      <= head_entry.wen2;
            end else begin
                reg_write <= 1'b0;
                enable    <= 1'b0;
            end
        end
    end

`ifdef WB_FORWARD_EN
    // Oldest first so later (younger) matches overwrite; port 2 after port 1.
    always_comb begin
        wb_entry_t        fe;
        logic [PTR_W-1:0] slot;
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fe       = '0;
        slot     = '0;
        if (reg_write && (write_reg1 == fwd_reg)) begin
            fwd_hit  = 1'b1;
            fwd_data = write_data1;
        end
        if (enable && (write_reg2 == fwd_reg)) begin
            fwd_hit  = 1'b1;
            fwd_data = write_data2;
        end
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr + PTR_W'(i);
            fe   = entries_flat[slot*ENT_W +: ENT_W];
            if (CNT_W'(i) < count) begin
                if (fe.wen1 && (fe.reg1 == fwd_reg)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = fe.data1;
                end
                if (fe.wen2 && (fe.reg2 == fwd_reg)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = fe.data2;
                end
            end
        end
        if (fwd_reg == '0) begin
            fwd_hit  = 1'b0;
            fwd_data = '0;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit with a behavioural register_block model.
// Forwarding checks are compiled in when WB_FORWARD_EN is defined.
module tb_writeback_unit;
    import writeback_pkg::*;

    localparam int DEPTH = 4;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  in_valid, in_ready;
    logic                  in_wen1, in_wen2;
    logic [REG_ADDR_W-1:0] in_reg1, in_reg2;
    logic [DATA_W-1:0]     in_data1, in_data2;
    logic                  drain_hold, flush;
    logic [REG_ADDR_W-1:0] write_reg1, write_reg2;
    logic [DATA_W-1:0]     write_data1, write_data2;
    logic                  reg_write, enable;
`ifdef WB_FORWARD_EN
    logic [REG_ADDR_W-1:0] fwd_reg;
    logic                  fwd_hit;
    logic [DATA_W-1:0]     fwd_data;
`endif

    writeback_unit #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_wen1     (in_wen1),
        .in_wen2     (in_wen2),
        .in_reg1     (in_reg1),
        .in_reg2     (in_reg2),
        .in_data1    (in_data1),
        .in_data2    (in_data2),
        .drain_hold  (drain_hold),
        .flush       (flush),
        .write_reg1  (write_reg1),
        .write_reg2  (write_reg2),
        .write_data1 (write_data1),
        .write_data2 (write_data2),
        .reg_write   (reg_write),
        .enable      (enable)
`ifdef WB_FORWARD_EN
        ,
        .fwd_reg     (fwd_reg),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic [4:0]  r1;
        logic [31:0] d1;
        logic        en;
        logic [4:0]  r2;
        logic [31:0] d2;
    } exp_t;

    exp_t        sb[$];
    exp_t        m;
    logic [31:0] rf [32];
    logic        acc;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    initial foreach (rf[i]) rf[i] = '0;

    // register_block model: commits on an edge where strobes are high and it is not busy
    always @(posedge clk) begin
        if (!reset && !drain_hold) begin
            if (reg_write && write_reg1 != 0) rf[write_reg1] <= write_data1;
            if (enable && write_reg2 != 0)    rf[write_reg2] <= write_data2;
        end
    end

    // Each output-stage value is consumed once, on the cycle it is allowed to commit
    always @(negedge clk) begin
        if (!reset && !drain_hold && (reg_write || enable)) begin
            if (sb.size() == 0) begin
                check_val("strobe_without_expect", {30'd0, reg_write, enable}, 32'd0);
            end else begin
                m = sb.pop_front();
                check_val("drain_reg_write", {31'd0, reg_write}, {31'd0, m.rw});
                check_val("drain_enable", {31'd0, enable}, {31'd0, m.en});
                if (m.rw) begin
                    check_val("drain_write_reg1", {27'd0, write_reg1}, {27'd0, m.r1});
                    check_val("drain_write_data1", write_data1, m.d1);
                end
                if (m.en) begin
                    check_val("drain_write_reg2", {27'd0, write_reg2}, {27'd0, m.r2});
                    check_val("drain_write_data2", write_data2, m.d2);
                end
            end
        end
    end

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic w1, input logic w2, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [31:0] d1, input logic [31:0] d2);
        logic s1, s2, squash;
        in_valid = 1'b1;
        in_wen1  = w1;
        in_wen2  = w2;
        in_reg1  = r1;
        in_reg2  = r2;
        in_data1 = d1;
        in_data2 = d2;
        @(negedge clk);
        acc    = in_ready;
        squash = flush || reset;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_wen1  = 1'b0;
        in_wen2  = 1'b0;
        s1 = w1 && (r1 != 0);
        s2 = w2 && (r2 != 0);
        if (s1 && s2 && (r1 == r2)) s1 = 1'b0;
        if (acc && !squash && (s1 || s2))
            sb.push_back('{rw: s1, r1: r1, d1: d1, en: s2, r2: r2, d2: d2});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; drain_hold = 1'b0;
        in_valid = 1'b0; in_wen1 = 1'b0; in_wen2 = 1'b0;
        in_reg1 = '0; in_reg2 = '0; in_data1 = '0; in_data2 = '0;
`ifdef WB_FORWARD_EN
        fwd_reg = 5'd0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_reg_write", {31'd0, reg_write}, 32'd0);
        check_val("reset_enable", {31'd0, enable}, 32'd0);
        check_val("reset_write_reg1", {27'd0, write_reg1}, 32'd0);
        check_val("reset_write_reg2", {27'd0, write_reg2}, 32'd0);
        check_val("reset_write_data1", write_data1, 32'd0);
        check_val("reset_write_data2", write_data2, 32'd0);
        check_val("reset_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef WB_FORWARD_EN
        fwd_reg = 5'd10;
        #1;
        check_val("reset_fwd_hit", {31'd0, fwd_hit}, 32'd0);
        check_val("reset_fwd_data", fwd_data, 32'd0);
        fwd_reg = 5'd0;
`endif
        reset = 1'b0;
        idle(1);

        // single write, with explicit latency
        push(1'b1, 1'b0, 5'd10, 5'd0, 32'hFFFF_FFFF, 32'd0);
        @(negedge clk);
        check_val("latency_edge_n", {31'd0, reg_write}, 32'd0);
        @(negedge clk);
        check_val("latency_edge_n1", {31'd0, reg_write}, 32'd1);
        @(posedge clk);
        #1;
        check_val("rf10_single", rf[10], 32'hFFFF_FFFF);

        // dual write, collision, $0 suppression
        idle(2);
        push(1'b1, 1'b1, 5'd11, 5'd12, 32'h0000_00AA, 32'h0000_00BB);
        push(1'b1, 1'b1, 5'd13, 5'd13, 32'd5, 32'd7);
        push(1'b1, 1'b1, 5'd0, 5'd14, 32'h99, 32'h55);
        push(1'b0, 1'b0, 5'd9, 5'd9, 32'h1, 32'h2);
        idle(4);
        check_val("rf11_dual", rf[11], 32'hAA);
        check_val("rf12_dual", rf[12], 32'hBB);
        check_val("rf13_collision", rf[13], 32'd7);
        check_val("rf0_zero", rf[0], 32'd0);
        check_val("rf14_port2", rf[14], 32'h55);
        check_val("rf9_noop", rf[9], 32'd0);

        // full / backpressure
        drain_hold = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            push(1'b1, 1'b0, 5'(k), 5'd0, 32'h100 + k, 32'd0);
            check_val("full_accept", {31'd0, acc}, (k <= 4) ? 32'd1 : 32'd0);
            if (k == 4) check_val("in_ready_full", {31'd0, in_ready}, 32'd0);
        end
        drain_hold = 1'b0;
        idle(5);
        @(negedge clk);
        check_val("full_drain_strobes", {30'd0, reg_write, enable}, 32'd0);
        check_val("full_drain_sb", sb.size(), 32'd0);
        check_val("rf4_full", rf[4], 32'h104);
        check_val("rf5_rejected", rf[5], 32'd0);

        // sustained throughput, alternating ports
        idle(1);
        push(1'b1, 1'b0, 5'd15, 5'd0, 32'hA15, 32'd0);
        push(1'b0, 1'b1, 5'd0, 5'd16, 32'd0, 32'hB16);
        push(1'b1, 1'b0, 5'd17, 5'd0, 32'hA17, 32'd0);
        push(1'b0, 1'b1, 5'd0, 5'd18, 32'd0, 32'hB18);
        idle(3);
        check_val("thru_sb", sb.size(), 32'd0);
        check_val("rf18_thru", rf[18], 32'hB18);

        // flush mid-drain, with a simultaneous push
        drain_hold = 1'b1;
        for (int k = 21; k <= 24; k++) push(1'b1, 1'b0, 5'(k), 5'd0, 32'(k), 32'd0);
        drain_hold = 1'b0;
        @(posedge clk);
        #1;
        drain_hold = 1'b1;
        @(negedge clk);
        check_val("flush_pre_strobe", {31'd0, reg_write}, 32'd1);
        flush = 1'b1;
        push(1'b1, 1'b0, 5'd25, 5'd0, 32'd25, 32'd0);
        flush = 1'b0;
        sb.delete();
        @(negedge clk);
        check_val("flush_strobes", {30'd0, reg_write, enable}, 32'd0);
        check_val("flush_in_ready", {31'd0, in_ready}, 32'd1);
        drain_hold = 1'b0;
        idle(6);
        for (int k = 21; k <= 25; k++) check_val("flush_rf_untouched", rf[k], 32'd0);

        // reset mid-drain, with a simultaneous push
        drain_hold = 1'b1;
        for (int k = 26; k <= 29; k++) push(1'b1, 1'b0, 5'(k), 5'd0, 32'(k), 32'd0);
        drain_hold = 1'b0;
        @(posedge clk);
        #1;
        drain_hold = 1'b1;
        reset = 1'b1;
        push(1'b1, 1'b0, 5'd30, 5'd0, 32'd30, 32'd0);
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        check_val("reset_mid_strobes", {30'd0, reg_write, enable}, 32'd0);
        check_val("reset_mid_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("reset_mid_write_reg1", {27'd0, write_reg1}, 32'd0);
        check_val("reset_mid_write_data1", write_data1, 32'd0);
        drain_hold = 1'b0;
        idle(6);
        for (int k = 26; k <= 30; k++) check_val("reset_rf_untouched", rf[k], 32'd0);

`ifdef WB_FORWARD_EN
        drain_hold = 1'b1;
        push(1'b1, 1'b0, 5'd20, 5'd0, 32'd1, 32'd0);
        push(1'b0, 1'b1, 5'd0, 5'd20, 32'd0, 32'd2);
        fwd_reg = 5'd20;
        #1;
        check_val("fwd_hit_queued", {31'd0, fwd_hit}, 32'd1);
        check_val("fwd_data_youngest", fwd_data, 32'd2);
        fwd_reg = 5'd0;
        #1;
        check_val("fwd_hit_reg0", {31'd0, fwd_hit}, 32'd0);
        fwd_reg = 5'd20;
        drain_hold = 1'b0;
        @(posedge clk);
        #1;
        drain_hold = 1'b1;
        #1;
        check_val("fwd_data_over_stage", fwd_data, 32'd2);
        drain_hold = 1'b0;
        idle(4);
        check_val("fwd_hit_drained", {31'd0, fwd_hit}, 32'd0);
        check_val("rf20_fwd", rf[20], 32'd2);
        fwd_reg = 5'd0;
`endif

        check_val("final_sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
